// File: rtl/jtdsp16_rom_arb.sv
// Shares the program-ROM port between table reads and instruction fetches, one access at a time.
// Latency: 2 cen cycles on a hit, 3+wait for a fetch, 5+waits for table+fetch; cpu_cen held low meanwhile.
module jtdsp16_rom_arb #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter bit HIT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [AW-1:0] fetch_addr,
  input  logic          tbl_req,
  input  logic [AW-1:0] tbl_addr,
  output logic          cpu_cen,
  output logic [DW-1:0] fetch_data,
  output logic [DW-1:0] tbl_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_cs,
  input  logic          mem_ok,
  input  logic [DW-1:0] mem_data,
  output logic [7:0]    stall_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TBL   = 3'd1,
    FETCH = 3'd2,
    GAP   = 3'd3,
    READY = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] fetch_reg;
  logic [AW-1:0] last_addr;
  logic          need_fetch;
  logic          hit_valid;
  logic          ready;
  logic          hit;

  assign hit = HIT_EN && hit_valid && (fetch_addr == last_addr);

  // ready is the registered enable; masking with cen keeps the pulse inside a cen cycle
  assign cpu_cen = ready & cen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_reg  <= '0;
      last_addr  <= '0;
      need_fetch <= 1'b0;
      hit_valid  <= 1'b0;
      ready      <= 1'b0;
      mem_cs     <= 1'b0;
      mem_addr   <= '0;
      fetch_data <= '0;
      tbl_data   <= '0;
      stall_cnt  <= '0;
    end else if (cen) begin
      if (!ready && stall_cnt != 8'hFF) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          fetch_reg  <= fetch_addr;
          need_fetch <= !hit;
          if (tbl_req) begin
            state    <= TBL;
            mem_cs   <= 1'b1;
            mem_addr <= tbl_addr;
          end else if (!hit) begin
            state    <= FETCH;
            mem_cs   <= 1'b1;
            mem_addr <= fetch_addr;
          end else begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        TBL: begin
          if (mem_ok && mem_cs) begin
            tbl_data <= mem_data;
            mem_cs   <= 1'b0;
            state    <= GAP;
          end
        end
        // One idle cycle so the controller sees a fresh request edge for the fetch
        GAP: begin
          if (need_fetch) begin
            state    <= FETCH;
            mem_cs   <= 1'b1;
            mem_addr <= fetch_reg;
          end else begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_ok && mem_cs) begin
            fetch_data <= mem_data;
            last_addr  <= fetch_reg;
            hit_valid  <= 1'b1;
            mem_cs     <= 1'b0;
            ready      <= 1'b1;
            state      <= READY;
          end
        end
        READY: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ready  <= 1'b0;
          mem_cs <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtdsp16_rom_arb.sv
// Bench for jtdsp16_rom_arb: reference model of per-instruction latency, ROM accesses and latched words.
module tb_jtdsp16_rom_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic [15:0] fetch_addr;
  logic        tbl_req;
  logic [15:0] tbl_addr;
  logic        cpu_cen;
  logic [15:0] fetch_data;
  logic [15:0] tbl_data;
  logic [15:0] mem_addr;
  logic        mem_cs;
  logic        mem_ok;
  logic [15:0] mem_data;
  logic [7:0]  stall_cnt;

  jtdsp16_rom_arb #(.AW(16), .DW(16), .HIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .fetch_addr(fetch_addr), .tbl_req(tbl_req), .tbl_addr(tbl_addr),
    .cpu_cen(cpu_cen), .fetch_data(fetch_data), .tbl_data(tbl_data),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_ok(mem_ok), .mem_data(mem_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;

  // cen: always high, or one cycle in three; cen_hold forces it low
  logic cen_hold = 1'b1;
  logic cen_div  = 1'b0;
  int   cen_ph   = 0;
  initial begin
    cen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cen_ph = (cen_ph == 2) ? 0 : cen_ph + 1;
      cen    = !cen_hold && (!cen_div || cen_ph == 0);
    end
  end

  // ROM model: answers mem_wait clocks after the request rises, holds ok while requested
  int          mem_wait  = 0;
  int          cs_cnt    = 0;
  logic        force_ok  = 1'b0;
  logic [15:0] rom_seed  = 16'h0000;

  function automatic logic [15:0] rom_word(input logic [15:0] a, input logic [15:0] s);
    return {a[7:0], a[15:8]} ^ s ^ 16'h3C5A;
  endfunction

  always @(posedge clk) cs_cnt <= mem_cs ? cs_cnt + 1 : 0;
  assign mem_ok   = force_ok | (mem_cs && cs_cnt >= mem_wait);
  assign mem_data = force_ok ? 16'hBEEF : rom_word(mem_addr, rom_seed);

  typedef struct {
    int          lat;
    int          nacc;
    logic [15:0] acc0;
    logic [15:0] acc1;
    logic [15:0] fdat;
    logic [15:0] tdat;
    int          stall;
  } exp_t;

  typedef struct {
    int          lat;
    int          nacc;
    logic [15:0] acc0;
    logic [15:0] acc1;
    logic [15:0] fdat;
    logic [15:0] tdat;
    int          stall;
    int          unstable;
    int          cen_viol;
    logic        after;
  } obs_t;

  // Reference model state
  logic [15:0] m_last  = 16'h0000;
  logic        m_valid = 1'b0;
  logic [15:0] m_fdat  = 16'h0000;
  logic [15:0] m_tdat  = 16'h0000;
  int          m_stall = 0;

  task automatic model_reset();
    m_valid = 1'b0;
    m_fdat  = 16'h0000;
    m_tdat  = 16'h0000;
    m_stall = 0;
  endtask

  task automatic model_instr(input logic tr, input logic [15:0] ta, input logic [15:0] fa,
                             input int w, output exp_t e);
    logic need_f;
    need_f = !(m_valid && fa == m_last);
    e.lat  = 2 + (tr ? 2 + w : 0) + (need_f ? 1 + w : 0);
    e.nacc = 0;
    e.acc0 = 16'h0000;
    e.acc1 = 16'h0000;
    if (tr) begin
      e.acc0 = ta;
      e.nacc = 1;
      m_tdat = rom_word(ta, rom_seed);
    end
    if (need_f) begin
      if (e.nacc == 0) e.acc0 = fa;
      else e.acc1 = fa;
      e.nacc  = e.nacc + 1;
      m_fdat  = rom_word(fa, rom_seed);
      m_last  = fa;
      m_valid = 1'b1;
    end
    m_stall = m_stall + e.lat - 1;
    if (m_stall > 255) m_stall = 255;
    e.fdat  = m_fdat;
    e.tdat  = m_tdat;
    e.stall = m_stall;
  endtask

  // Drives one instruction from an IDLE-cycle negedge and observes until the cpu_cen pulse
  task automatic run_instr(input logic tr, input logic [15:0] ta, input logic [15:0] fa,
                           input int w, output obs_t o);
    logic        prev_cs;
    logic        done;
    logic [15:0] held;
    o = '{default: 0};
    tbl_req    = tr;
    tbl_addr   = ta;
    fetch_addr = fa;
    mem_wait   = w;
    cen_hold   = 1'b0;
    prev_cs    = mem_cs;
    held       = mem_addr;
    done       = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cen) o.lat++;
      if (cpu_cen && !cen) o.cen_viol++;
      if (mem_cs && !prev_cs) begin
        if (o.nacc == 0) o.acc0 = mem_addr;
        else if (o.nacc == 1) o.acc1 = mem_addr;
        o.nacc++;
        held = mem_addr;
      end else if (mem_cs && mem_addr !== held) begin
        o.unstable++;
      end
      prev_cs = mem_cs;
      if (cpu_cen === 1'b1) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    o.fdat  = fetch_data;
    o.tdat  = tbl_data;
    o.stall = stall_cnt;
    if (!done) o.lat = -1;
    @(posedge clk);
    @(negedge clk);
    o.after = cpu_cen;
  endtask

  task automatic issue(input logic tr, input logic [15:0] ta, input logic [15:0] fa,
                       input int w, output exp_t e, output obs_t o);
    rom_seed = 16'($urandom);
    model_instr(tr, ta, fa, w, e);
    run_instr(tr, ta, fa, w, o);
  endtask

  task automatic test_reset();
    cen_hold   = 1'b1;
    rst_n      = 1'b0;
    tbl_req    = 1'b0;
    tbl_addr   = 16'h0000;
    fetch_addr = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++; if (cpu_cen !== 1'b0) begin miss++; $display("FAIL reset_cpu_cen: got %b exp 0", cpu_cen); end
    vec++; if (mem_cs !== 1'b0) begin miss++; $display("FAIL reset_mem_cs: got %b exp 0", mem_cs); end
    vec++; if (mem_addr !== 16'h0000) begin miss++; $display("FAIL reset_mem_addr: got %h exp 0000", mem_addr); end
    vec++; if (fetch_data !== 16'h0000) begin miss++; $display("FAIL reset_fetch_data: got %h exp 0000", fetch_data); end
    vec++; if (tbl_data !== 16'h0000) begin miss++; $display("FAIL reset_tbl_data: got %h exp 0000", tbl_data); end
    vec++; if (stall_cnt !== 8'd0) begin miss++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cnt); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_fetch();
    exp_t e; obs_t o;
    issue(1'b0, 16'h0000, 16'h0000, 2, e, o);
    vec++; if (o.lat !== 5) begin miss++; $display("FAIL first_latency: got %0d exp 5", o.lat); end
    vec++; if (o.nacc !== 1 || o.acc0 !== 16'h0000) begin miss++; $display("FAIL first_access: got n=%0d a=%h exp n=1 a=0000", o.nacc, o.acc0); end
    vec++; if (o.fdat !== e.fdat) begin miss++; $display("FAIL first_fetch_data: got %h exp %h", o.fdat, e.fdat); end
    vec++; if (o.after !== 1'b0) begin miss++; $display("FAIL first_single_pulse: got %b exp 0", o.after); end
    vec++; if (o.stall !== e.stall) begin miss++; $display("FAIL first_stall: got %0d exp %0d", o.stall, e.stall); end
  endtask

  task automatic test_hit();
    exp_t e1, e2; obs_t o1, o2;
    issue(1'b0, 16'h0000, 16'h0010, 1, e1, o1);
    issue(1'b0, 16'h0000, 16'h0010, 1, e2, o2);
    vec++; if (o1.lat !== e1.lat) begin miss++; $display("FAIL hit_first_latency: got %0d exp %0d", o1.lat, e1.lat); end
    vec++; if (o2.lat !== 2) begin miss++; $display("FAIL hit_latency: got %0d exp 2", o2.lat); end
    vec++; if (o2.nacc !== 0) begin miss++; $display("FAIL hit_no_access: got %0d accesses exp 0", o2.nacc); end
    vec++; if (o2.fdat !== o1.fdat || o2.fdat !== e2.fdat) begin miss++; $display("FAIL hit_fetch_held: got %h exp %h", o2.fdat, e2.fdat); end
  endtask

  task automatic test_table();
    exp_t e; obs_t o;
    issue(1'b1, 16'h0800, 16'h0011, 1, e, o);
    vec++; if (o.nacc !== 2 || o.acc0 !== 16'h0800 || o.acc1 !== 16'h0011) begin miss++; $display("FAIL table_order: got n=%0d %h,%h exp n=2 0800,0011", o.nacc, o.acc0, o.acc1); end
    vec++; if (o.lat !== 7) begin miss++; $display("FAIL table_latency: got %0d exp 7", o.lat); end
    vec++; if (o.tdat !== e.tdat) begin miss++; $display("FAIL table_tbl_data: got %h exp %h", o.tdat, e.tdat); end
    vec++; if (o.fdat !== e.fdat) begin miss++; $display("FAIL table_fetch_data: got %h exp %h", o.fdat, e.fdat); end
  endtask

  task automatic test_long_stall();
    exp_t e; obs_t o;
    issue(1'b0, 16'h0000, 16'h1234, 20, e, o);
    vec++; if (o.lat !== 23) begin miss++; $display("FAIL stall20_latency: got %0d exp 23", o.lat); end
    vec++; if (o.unstable !== 0) begin miss++; $display("FAIL stall20_addr_stable: got %0d changes exp 0", o.unstable); end
    vec++; if (o.stall !== e.stall) begin miss++; $display("FAIL stall20_count: got %0d exp %0d", o.stall, e.stall); end
    issue(1'b0, 16'h0000, 16'h1235, 300, e, o);
    vec++; if (o.lat !== 303) begin miss++; $display("FAIL stall300_latency: got %0d exp 303", o.lat); end
    vec++; if (o.stall !== 255 || e.stall !== 255) begin miss++; $display("FAIL stall300_saturate: got %0d exp 255", o.stall); end
    issue(1'b0, 16'h0000, 16'h1235, 0, e, o);
    vec++; if (o.stall !== 255) begin miss++; $display("FAIL stall_no_wrap: got %0d exp 255", o.stall); end
  endtask

  task automatic test_reset_mid_tbl();
    exp_t e; obs_t o;
    logic found;
    issue(1'b0, 16'h0000, 16'h0040, 0, e, o);
    vec++; if (o.fdat !== e.fdat) begin miss++; $display("FAIL midrst_prefetch: got %h exp %h", o.fdat, e.fdat); end
    rom_seed   = 16'($urandom);
    tbl_req    = 1'b1;
    tbl_addr   = 16'h0900;
    fetch_addr = 16'h0040;
    mem_wait   = 50;
    found      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_cs === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    vec++; if (!found || mem_addr !== 16'h0900) begin miss++; $display("FAIL midrst_tbl_request: got cs=%b addr=%h exp cs=1 addr=0900", found, mem_addr); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec++; if (mem_cs !== 1'b0) begin miss++; $display("FAIL midrst_cs_async: got %b exp 0", mem_cs); end
    cen_hold = 1'b1;
    tbl_req  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    force_ok = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++; if (tbl_data !== 16'h0000 || fetch_data !== 16'h0000) begin miss++; $display("FAIL midrst_late_ok: got tbl=%h fetch=%h exp 0000", tbl_data, fetch_data); end
    vec++; if (mem_cs !== 1'b0 || stall_cnt !== 8'd0) begin miss++; $display("FAIL midrst_idle: got cs=%b stall=%0d exp 0,0", mem_cs, stall_cnt); end
    force_ok = 1'b0;
    model_reset();
    issue(1'b0, 16'h0000, 16'h0040, 1, e, o);
    vec++; if (o.nacc !== 1 || o.acc0 !== 16'h0040) begin miss++; $display("FAIL midrst_refetch: got n=%0d a=%h exp n=1 a=0040", o.nacc, o.acc0); end
    vec++; if (o.lat !== 4 || o.fdat !== e.fdat) begin miss++; $display("FAIL midrst_refetch_data: got lat=%0d %h exp lat=4 %h", o.lat, o.fdat, e.fdat); end
  endtask

  task automatic test_cen_div();
    exp_t e; obs_t o;
    cen_div = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(logic'(i % 2), 16'h0A00 + 16'(i), 16'h0300 + 16'(i / 2), 0, e, o);
      vec++; if (o.lat !== e.lat) begin miss++; $display("FAIL cen_div_latency[%0d]: got %0d exp %0d", i, o.lat, e.lat); end
      vec++; if (o.cen_viol !== 0) begin miss++; $display("FAIL cen_div_gating[%0d]: got %0d pulses without cen exp 0", i, o.cen_viol); end
      vec++; if (o.fdat !== e.fdat || o.tdat !== e.tdat) begin miss++; $display("FAIL cen_div_data[%0d]: got %h/%h exp %h/%h", i, o.fdat, o.tdat, e.fdat, e.tdat); end
    end
    cen_div = 1'b0;
  endtask

  task automatic test_random();
    exp_t e; obs_t o;
    logic [15:0] pool [6];
    logic        tr;
    pool = '{16'h0010, 16'h8010, 16'hFFFF, 16'h0000, 16'h0011, 16'h0800};
    for (int i = 0; i < 40; i++) begin
      tr = ($urandom_range(0, 2) == 0);
      issue(tr, 16'($urandom), pool[$urandom_range(0, 5)], $urandom_range(0, 3), e, o);
      vec++; if (o.lat !== e.lat) begin miss++; $display("FAIL rand_latency[%0d]: got %0d exp %0d", i, o.lat, e.lat); end
      vec++; if (o.nacc !== e.nacc || o.acc0 !== e.acc0 || o.acc1 !== e.acc1) begin miss++; $display("FAIL rand_access[%0d]: got n=%0d %h,%h exp n=%0d %h,%h", i, o.nacc, o.acc0, o.acc1, e.nacc, e.acc0, e.acc1); end
      vec++; if (o.fdat !== e.fdat || o.tdat !== e.tdat) begin miss++; $display("FAIL rand_data[%0d]: got %h/%h exp %h/%h", i, o.fdat, o.tdat, e.fdat, e.tdat); end
      vec++; if (o.stall !== e.stall || o.after !== 1'b0) begin miss++; $display("FAIL rand_stall_pulse[%0d]: got stall=%0d after=%b exp %0d,0", i, o.stall, o.after, e.stall); end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    tbl_req    = 1'b0;
    tbl_addr   = 16'h0000;
    fetch_addr = 16'h0000;
    test_reset();
    test_first_fetch();
    test_hit();
    test_table();
    test_long_stall();
    test_reset_mid_tbl();
    test_cen_div();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
